// File: rtl/wb_rr_arbiter_if.sv
// rtl/wb_rr_arbiter_if.sv - Wishbone signal bundle between NM masters, the round-robin arbiter and one shared slave
interface wb_rr_arbiter_if #(
   parameter int NM = 2,
   parameter int AW = 32,
   parameter int DW = 32
);
   // master side, master k at slice k
   logic [NM*AW-1:0]     m_adr_i;
   logic [NM*DW-1:0]     m_dat_i;
   logic [NM-1:0]        m_we_i;
   logic [NM*(DW/8)-1:0] m_sel_i;
   logic [NM-1:0]        m_stb_i;
   logic [NM-1:0]        m_cyc_i;
   logic [DW-1:0]        m_dat_o;
   logic [NM-1:0]        m_ack_o;
   logic [NM-1:0]        m_err_o;
   logic [NM-1:0]        m_rty_o;

   // slave side, owner's signals muxed through
   logic [AW-1:0]        s_adr_o;
   logic [DW-1:0]        s_dat_o;
   logic                 s_we_o;
   logic [DW/8-1:0]      s_sel_o;
   logic                 s_stb_o;
   logic                 s_cyc_o;
   logic [DW-1:0]        s_dat_i;
   logic                 s_ack_i;
   logic                 s_err_i;
   logic                 s_rty_i;

   logic [NM-1:0]        grant_o;

   // arbiter view: it answers the masters and drives the shared slave
   modport slave (
      input  m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i, m_cyc_i,
      output m_dat_o, m_ack_o, m_err_o, m_rty_o,
      output s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
      input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
      output grant_o
   );

   // environment view: the requesting masters plus the downstream slave
   modport master (
      output m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i, m_cyc_i,
      input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
      input  s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
      output s_dat_i, s_ack_i, s_err_i, s_rty_i,
      input  grant_o
   );
endinterface

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone arbiter, NM masters onto one slave; macro ARB_TIMEOUT_EN adds the stalled-slave watchdog
module wb_rr_arbiter #(
   parameter int NM      = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           reset,
   wb_rr_arbiter_if.slave bus
);
   localparam int IW = $clog2(NM);
   localparam int SW = DW / 8;

   if (NM < 2 || NM > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
      $error("wb_rr_arbiter: NM must be 2..8 and TIMEOUT 1..65535");
   end

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t        state, state_n;
   logic [IW-1:0] own, own_n;
   logic [IW-1:0] last, last_n;
   logic [IW-1:0] pick, cand;
   logic [NM-1:0] grant_q, grant_n;
   logic          busy;
   logic          wd_fire;

   assign busy = (state == BUSY);

   // Rotating priority: the requester nearest after the last owner wins
   always_comb begin
      pick = last;
      cand = '0;
      for (int i = NM; i >= 1; i--) begin
         cand = IW'((int'(last) + i) % NM);
         if (bus.m_cyc_i[cand]) pick = cand;
      end
   end

   // Ownership transitions; the one-hot grant is decoded here so it can be registered with the state
   always_comb begin
      state_n = state;
      own_n   = own;
      last_n  = last;
      case (state)
         IDLE: begin
            if (|bus.m_cyc_i) begin
               state_n = BUSY;
               own_n   = pick;
               last_n  = pick;
            end
         end
         BUSY: begin
            if (!bus.m_cyc_i[own]) state_n = IDLE;
         end
      endcase
      grant_n = '0;
      if (state_n == BUSY) grant_n[own_n] = 1'b1;
   end

   // State, owner, rotation pointer and glitch-free grant register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         own     <= '0;
         last    <= IW'(NM - 1);
         grant_q <= '0;
      end else begin
         state   <= state_n;
         own     <= own_n;
         last    <= last_n;
         grant_q <= grant_n;
      end
   end

   // Slave-side mux: owner's bus while BUSY, all zero while IDLE; a watchdog hit drops cyc/stb for that cycle
   always_comb begin
      bus.s_cyc_o = 1'b0;
      bus.s_stb_o = 1'b0;
      bus.s_adr_o = '0;
      bus.s_dat_o = '0;
      bus.s_we_o  = 1'b0;
      bus.s_sel_o = '0;
      if (busy) begin
         bus.s_cyc_o = bus.m_cyc_i[own] & ~wd_fire;
         bus.s_stb_o = bus.m_cyc_i[own] & bus.m_stb_i[own] & ~wd_fire;
         bus.s_adr_o = bus.m_adr_i[int'(own)*AW +: AW];
         bus.s_dat_o = bus.m_dat_i[int'(own)*DW +: DW];
         bus.s_we_o  = bus.m_we_i[own];
         bus.s_sel_o = bus.m_sel_i[int'(own)*SW +: SW];
      end
   end

   // Responses reach the granted master only; a watchdog error replaces whatever the slave says that cycle
   assign bus.m_dat_o = bus.s_dat_i;
   assign bus.m_ack_o = {NM{bus.s_ack_i & ~wd_fire}} & grant_q;
   assign bus.m_err_o = {NM{bus.s_err_i |  wd_fire}} & grant_q;
   assign bus.m_rty_o = {NM{bus.s_rty_i & ~wd_fire}} & grant_q;
   assign bus.grant_o = grant_q;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] wd_cnt;
   logic          s_resp;

   assign s_resp  = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
   assign wd_fire = busy & (wd_cnt == CW'(TIMEOUT));

   // Count unanswered strobe cycles; restart on any answer, on firing and whenever ownership ends
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt <= '0;
      end else if (state_n != BUSY || s_resp || wd_fire) begin
         wd_cnt <= '0;
      end else if (bus.s_stb_o) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign wd_fire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - self-checking bench for wb_rr_arbiter against an ownership/rotation model
`timescale 1ns/1ps
module tb_wb_rr_arbiter;
   localparam int NM = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic auto_ack = 1'b0;
   logic man_ack  = 1'b0;
   logic log_en   = 1'b0;
   int   errors   = 0;
   int   checks   = 0;

   logic [NM-1:0]      seq [$];
   logic [NM+AW:0]     acc_log [$];
   logic [NM-1:0]      exp_seq [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

   wb_rr_arbiter_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

   wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.s_ack_i = auto_ack ? bus.s_stb_o : man_ack;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   int m_owner = -1;
   int m_last  = NM - 1;
   int m_wd    = 0;

   function automatic int rr_pick(input int last, input logic [NM-1:0] req);
      for (int i = 1; i <= NM; i++)
         if (req[(last + i) % NM]) return (last + i) % NM;
      return -1;
   endfunction

   function automatic bit wd_fire_now();
      return TO_EN && m_owner >= 0 && m_wd == TO;
   endfunction

   function automatic bit exp_stb();
      return m_owner >= 0 && !wd_fire_now() && bus.m_cyc_i[m_owner] && bus.m_stb_i[m_owner];
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_owner <= -1;
         m_last  <= NM - 1;
         m_wd    <= 0;
      end else begin
         if (m_owner < 0) begin
            if (|bus.m_cyc_i) begin
               m_owner <= rr_pick(m_last, bus.m_cyc_i);
               m_last  <= rr_pick(m_last, bus.m_cyc_i);
            end
         end else if (!bus.m_cyc_i[m_owner]) begin
            m_owner <= -1;
         end
         if (!TO_EN || m_owner < 0 || !bus.m_cyc_i[m_owner] || wd_fire_now() ||
             bus.s_ack_i || bus.s_err_i || bus.s_rty_i)
            m_wd <= 0;
         else if (exp_stb())
            m_wd <= m_wd + 1;
      end
   end

   task automatic compare_outputs();
      logic [NM-1:0] oh    = '0;
      logic          fire  = 1'b0;
      logic          e_cyc = 1'b0;
      logic          e_stb = 1'b0;
      logic          e_we  = 1'b0;
      logic [AW-1:0] e_adr = '0;
      logic [DW-1:0] e_dat = '0;
      logic [SW-1:0] e_sel = '0;
      if (m_owner >= 0) begin
         oh[m_owner] = 1'b1;
         fire  = wd_fire_now();
         e_cyc = bus.m_cyc_i[m_owner] && !fire;
         e_stb = exp_stb();
         e_we  = bus.m_we_i[m_owner];
         e_adr = bus.m_adr_i[m_owner*AW +: AW];
         e_dat = bus.m_dat_i[m_owner*DW +: DW];
         e_sel = bus.m_sel_i[m_owner*SW +: SW];
      end
      chk("cmp_grant", bus.grant_o, oh);
      chk("cmp_s_cyc", bus.s_cyc_o, e_cyc);
      chk("cmp_s_stb", bus.s_stb_o, e_stb);
      chk("cmp_s_adr", bus.s_adr_o, e_adr);
      chk("cmp_s_dat", bus.s_dat_o, e_dat);
      chk("cmp_s_we",  bus.s_we_o,  e_we);
      chk("cmp_s_sel", bus.s_sel_o, e_sel);
      chk("cmp_m_dat", bus.m_dat_o, bus.s_dat_i);
      chk("cmp_m_ack", bus.m_ack_o, (bus.s_ack_i && !fire) ? oh : '0);
      chk("cmp_m_err", bus.m_err_o, (bus.s_err_i || fire) ? oh : '0);
      chk("cmp_m_rty", bus.m_rty_o, (bus.s_rty_i && !fire) ? oh : '0);
   endtask

   always @(negedge clk) compare_outputs();

   always @(negedge clk)
      if (log_en && bus.s_stb_o && bus.s_ack_i)
         acc_log.push_back({bus.grant_o, bus.s_we_o, bus.s_adr_o});

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat);
      bus.m_adr_i[k*AW +: AW] = adr;
      bus.m_dat_i[k*DW +: DW] = dat;
      bus.m_we_i[k]           = we;
      bus.m_sel_i[k*SW +: SW] = we ? 4'h3 : 4'hF;
      bus.m_stb_i[k]          = 1'b1;
      bus.m_cyc_i[k]          = 1'b1;
   endtask

   task automatic drop(input int k);
      bus.m_stb_i[k] = 1'b0;
      bus.m_cyc_i[k] = 1'b0;
   endtask

   task automatic do_access(input int k, input logic [AW-1:0] adr, input logic we,
                            input logic [DW-1:0] dat, input bit keep_cyc);
      bit seen = 1'b0;
      set_req(k, adr, we, dat);
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         seen = bus.m_ack_o[k];
      end
      chk($sformatf("ack_seen_m%0d", k), seen, 1'b1);
      tick();
      bus.m_stb_i[k] = 1'b0;
      if (!keep_cyc) bus.m_cyc_i[k] = 1'b0;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      reset       = 1'b1;
      bus.m_adr_i = '0;
      bus.m_dat_i = '0;
      bus.m_we_i  = '0;
      bus.m_sel_i = '0;
      bus.m_stb_i = '0;
      bus.m_cyc_i = '0;
      bus.s_dat_i = '0;
      bus.s_err_i = 1'b0;
      bus.s_rty_i = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      chk("reset_grant", bus.grant_o, 2'b00);
      chk("reset_s_cyc", bus.s_cyc_o, 1'b0);
      tick();
      reset = 1'b0;

      // single master read with two wait states
      set_req(0, 32'h0000_1000, 1'b0, 32'h0);
      @(negedge clk);
      chk("t2_latency_grant", bus.grant_o, 2'b00);
      tick();
      @(negedge clk);
      chk("t2_grant", bus.grant_o, 2'b01);
      chk("t2_s_adr", bus.s_adr_o, 32'h0000_1000);
      tick();
      tick();
      bus.s_dat_i = 32'hDEAD_BEEF;
      man_ack     = 1'b1;
      @(negedge clk);
      chk("t2_m_ack", bus.m_ack_o, 2'b01);
      chk("t2_m_dat", bus.m_dat_o, 32'hDEAD_BEEF);
      tick();
      man_ack = 1'b0;
      drop(0);
      @(negedge clk);
      chk("t2_ack_one_cycle", bus.m_ack_o, 2'b00);
      tick();
      @(negedge clk);
      chk("t2_idle_grant", bus.grant_o, 2'b00);

      // reset in the middle of a master 1 read
      tick();
      set_req(1, 32'h0000_2000, 1'b0, 32'h0);
      tick();
      @(negedge clk);
      chk("t1_m1_grant", bus.grant_o, 2'b10);
      tick();
      reset   = 1'b1;
      man_ack = 1'b1;
      @(negedge clk);
      chk("t1_rst_grant", bus.grant_o, 2'b00);
      chk("t1_rst_s_cyc", bus.s_cyc_o, 1'b0);
      chk("t1_rst_m_ack", bus.m_ack_o, 2'b00);
      tick();
      reset   = 1'b0;
      man_ack = 1'b0;
      set_req(0, 32'h0000_1000, 1'b0, 32'h0);
      tick();
      @(negedge clk);
      chk("t1_first_winner", bus.grant_o, 2'b01);

      // round robin with both masters requesting
      tick();
      auto_ack = 1'b1;
      fork
         begin
            do_access(0, 32'h0000_1000, 1'b0, 32'h0, 1'b0);
            tick();
            tick();
            do_access(0, 32'h0000_1004, 1'b1, 32'h1111_2222, 1'b0);
         end
         begin
            do_access(1, 32'h0000_2000, 1'b0, 32'h0, 1'b0);
         end
         begin
            for (int n = 0; n < 10; n++) begin
               @(negedge clk);
               if (seq.size() == 0 || seq[$] !== bus.grant_o) seq.push_back(bus.grant_o);
            end
         end
      join
      for (int i = 0; i < 5; i++)
         chk($sformatf("t3_seq%0d", i), (i < seq.size()) ? seq[i] : 'x, exp_seq[i]);

      // atomic read-modify-write by master 1 while master 0 waits
      log_en = 1'b1;
      fork
         begin
            do_access(1, 32'h0000_0200, 1'b0, 32'h0, 1'b1);
            do_access(1, 32'h0000_0200, 1'b1, 32'hCAFE_F00D, 1'b0);
         end
         begin
            tick();
            tick();
            do_access(0, 32'h0000_0300, 1'b0, 32'h0, 1'b0);
         end
      join
      repeat (3) tick();
      log_en = 1'b0;
      chk("t4_log_len", acc_log.size(), 3);
      chk("t4_log0", (acc_log.size() > 0) ? acc_log[0] : 'x, {2'b10, 1'b0, 32'h0000_0200});
      chk("t4_log1", (acc_log.size() > 1) ? acc_log[1] : 'x, {2'b10, 1'b1, 32'h0000_0200});
      chk("t4_log2", (acc_log.size() > 2) ? acc_log[2] : 'x, {2'b01, 1'b0, 32'h0000_0300});

      // response isolation
      auto_ack = 1'b0;
      set_req(0, 32'h0000_0400, 1'b0, 32'h0);
      set_req(1, 32'h0000_0404, 1'b0, 32'h0);
      tick();
      @(negedge clk);
      chk("t5_grant", bus.grant_o, 2'b10);
      tick();
      man_ack = 1'b1;
      @(negedge clk);
      chk("t5_ack_owner_only", bus.m_ack_o, 2'b10);
      tick();
      man_ack     = 1'b0;
      bus.s_err_i = 1'b1;
      @(negedge clk);
      chk("t5_err_owner_only", bus.m_err_o, 2'b10);
      tick();
      bus.s_err_i = 1'b0;
      bus.s_rty_i = 1'b1;
      @(negedge clk);
      chk("t5_rty_owner_only", bus.m_rty_o, 2'b10);
      tick();
      bus.s_rty_i = 1'b0;
      drop(0);
      drop(1);
      tick();
      tick();
      man_ack     = 1'b1;
      bus.s_err_i = 1'b1;
      bus.s_rty_i = 1'b1;
      @(negedge clk);
      chk("t5_idle_grant", bus.grant_o, 2'b00);
      chk("t5_stray_ack", bus.m_ack_o, 2'b00);
      chk("t5_stray_err", bus.m_err_o, 2'b00);
      chk("t5_stray_rty", bus.m_rty_o, 2'b00);
      tick();
      man_ack     = 1'b0;
      bus.s_err_i = 1'b0;
      bus.s_rty_i = 1'b0;

      // stalled slave: watchdog build errors out on the fifth strobe cycle, default build just waits
      set_req(0, 32'h0000_0500, 1'b0, 32'h0);
      tick();
      for (int n = 1; n <= (TO_EN ? 6 : 100); n++) begin
         @(negedge clk);
         if (TO_EN && n == TO + 1) begin
            chk($sformatf("t6_stb_c%0d", n), bus.s_stb_o, 1'b0);
            chk($sformatf("t6_err_c%0d", n), bus.m_err_o, 2'b01);
         end else begin
            chk($sformatf("t6_stb_c%0d", n), bus.s_stb_o, 1'b1);
            chk($sformatf("t6_err_c%0d", n), bus.m_err_o, 2'b00);
         end
      end
      chk("t6_still_owner", bus.grant_o, 2'b01);
      tick();
      drop(0);
      repeat (3) tick();
      @(negedge clk);
      chk("end_idle_grant", bus.grant_o, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

endmodule
